// File: rtl/mult_share_arbiter_if.sv
// Requester, response and multiplier-side signals of mult_share_arbiter.
// slave is the arbiter's view; master is the view of the clients and multiplier around it.
interface mult_share_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
);
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_x;
    logic [N*W-1:0] req_y;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [2*W-1:0] resp_product;
    logic           resp_err;
    logic           mul_start;
    logic [W-1:0]   mul_x;
    logic [W-1:0]   mul_y;
    logic           mul_done;
    logic [2*W-1:0] mul_product;
    logic           busy;

    modport slave (
        input  req_valid, req_x, req_y, mul_done, mul_product,
        output req_ready, resp_valid, resp_product, resp_err, mul_start, mul_x, mul_y, busy
    );

    modport master (
        output req_valid, req_x, req_y, mul_done, mul_product,
        input  req_ready, resp_valid, resp_product, resp_err, mul_start, mul_x, mul_y, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one start/done multiplier among N requesters,
// with a watchdog that turns a missing completion into an error response.
module mult_share_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    mult_share_arbiter_if.slave   bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           grant_found;
    logic [IW-1:0]  grant_idx;
    logic [IW-1:0]  cand_idx;

    // First valid requester at or above ptr, wrapping from N-1 back to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand_idx = IW'((ptr_q + k) % N);
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        owner_d          = owner_q;
        x_d              = x_q;
        y_d              = y_q;
        prod_d           = prod_q;
        err_d            = err_q;
        cnt_d            = cnt_q;
        bus.req_ready    = '0;
        bus.resp_valid   = '0;
        bus.resp_product = '0;
        bus.resp_err     = 1'b0;
        bus.mul_start    = 1'b0;
        bus.mul_x        = x_q;
        bus.mul_y        = y_q;
        bus.busy         = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    bus.req_ready = N'(1) << grant_idx;
                    owner_d       = grant_idx;
                    x_d           = bus.req_x[grant_idx*W +: W];
                    y_d           = bus.req_y[grant_idx*W +: W];
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                bus.mul_start = 1'b1;
                cnt_d         = '0;
                state_d       = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (bus.mul_done) begin
                    prod_d  = bus.mul_product;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                bus.resp_valid   = N'(1) << owner_q;
                bus.resp_product = prod_q;
                bus.resp_err     = err_q;
                ptr_d            = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
                state_d          = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            x_q     <= x_d;
            y_q     <= y_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
